// File: rtl/router_pkt_reg_gen.sv
// router_pkt_reg_gen: router input register stage with its own packet FSM.
// Routes each accepted packet to one of NCH destination FIFOs. Holds a byte across a
// FIFO-full stall, checks XOR parity and discards packets whose address is out of range.
//
// Optional feature: define ROUTER_LEN_CHECK_EN to compare the header length field
// header[WIDTH-1:ADDR_W] with the received payload count (len_err). Undefined: len_err = 0.
//
// Ports:
//   clock        in   1      rising-edge clock
//   resetn       in   1      asynchronous active-low reset
//   pkt_valid    in   1      high for header/payload bytes; first low cycle is the parity byte
//   data_in      in   WIDTH  packet byte, held by the source while busy=1
//   fifo_full    in   NCH    per-channel FIFO full
//   busy         out  1      stall to source; data_in not consumed this cycle
//   dout         out  WIDTH  byte to FIFO
//   wr_en        out  1      FIFO write strobe qualifying dout
//   wr_sel       out  NCH    one-hot selected channel, header accept until return to IDLE
//   parity_done  out  1      one-cycle pulse at packet completion
//   err          out  1      parity mismatch, held until the next header accept
//   drop         out  1      one-cycle pulse when an illegal-address packet has been discarded
//   len_err      out  1      length mismatch, same timing as err
module router_pkt_reg_gen #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned NCH    = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             pkt_valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic [NCH-1:0]   fifo_full,
  output logic             busy,
  output logic [WIDTH-1:0] dout,
  output logic             wr_en,
  output logic [NCH-1:0]   wr_sel,
  output logic             parity_done,
  output logic             err,
  output logic             drop,
  output logic             len_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_DROP  = 3'd5;

  localparam logic [ADDR_W:0] NCH_LIM = (ADDR_W + 1)'(NCH);

  logic [2:0]        r_state;
  logic [WIDTH-1:0]  r_hdr;
  logic [NCH-1:0]    r_sel;
  logic [WIDTH-1:0]  r_hold;
  logic              r_is_par;
  logic [WIDTH-1:0]  r_int_par;
  logic [WIDTH-1:0]  r_pkt_par;
  logic [WIDTH-1:0]  r_dout;
  logic              r_wr_en;
  logic              r_parity_done;
  logic              r_err;
  logic              r_drop;

  logic [ADDR_W-1:0] w_addr;
  logic              w_addr_ok;
  logic [NCH-1:0]    w_sel_dec;
  logic              w_full;
  logic              w_hdr_acc;

  assign w_addr    = data_in[ADDR_W-1:0];
  assign w_addr_ok = ({1'b0, w_addr} < NCH_LIM);
  // Only the selected channel's full flag matters.
  assign w_full    = |(fifo_full & r_sel);
  assign w_hdr_acc = (r_state == S_IDLE) && pkt_valid && w_addr_ok;

  always_comb begin
    w_sel_dec = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (w_addr == ADDR_W'(i)) w_sel_dec[i] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_hdr         <= '0;
      r_sel         <= '0;
      r_hold        <= '0;
      r_is_par      <= 1'b0;
      r_int_par     <= '0;
      r_pkt_par     <= '0;
      r_dout        <= '0;
      r_wr_en       <= 1'b0;
      r_parity_done <= 1'b0;
      r_err         <= 1'b0;
      r_drop        <= 1'b0;
    end else begin
      r_wr_en       <= 1'b0;
      r_parity_done <= 1'b0;
      r_drop        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (pkt_valid) begin
            if (w_addr_ok) begin
              r_hdr     <= data_in;
              r_sel     <= w_sel_dec;
              r_err     <= 1'b0;
              r_int_par <= '0;
              r_state   <= S_HDR;
            end else begin
              r_state <= S_DROP;
            end
          end
        end
        S_HDR: begin
          if (!w_full) begin
            r_dout    <= r_hdr;
            r_wr_en   <= 1'b1;
            r_int_par <= r_hdr;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (!w_full) begin
            r_dout  <= data_in;
            r_wr_en <= 1'b1;
            if (pkt_valid) begin
              r_int_par <= r_int_par ^ data_in;
            end else begin
              r_pkt_par <= data_in;
              r_state   <= S_CHECK;
            end
          end else begin
            // Park the byte; the source sees busy from the next cycle on.
            r_hold   <= data_in;
            r_is_par <= !pkt_valid;
            r_state  <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!w_full) begin
            r_dout  <= r_hold;
            r_wr_en <= 1'b1;
            if (r_is_par) begin
              r_pkt_par <= r_hold;
              r_state   <= S_CHECK;
            end else begin
              r_int_par <= r_int_par ^ r_hold;
              r_state   <= S_DATA;
            end
          end
        end
        S_CHECK: begin
          r_parity_done <= 1'b1;
          r_err         <= (r_int_par != r_pkt_par);
          r_sel         <= '0;
          r_state       <= S_IDLE;
        end
        S_DROP: begin
          if (!pkt_valid) begin
            r_drop  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ROUTER_LEN_CHECK_EN
  localparam int unsigned CNT_W = WIDTH - ADDR_W;

  logic [CNT_W-1:0] r_cnt;
  logic             r_len_err;
  logic             w_cnt_inc;

  // A payload byte is counted when it is written, from DATA directly or from HOLD.
  assign w_cnt_inc = ((r_state == S_DATA) && pkt_valid && !w_full) ||
                     ((r_state == S_HOLD) && !r_is_par && !w_full);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt     <= '0;
      r_len_err <= 1'b0;
    end else begin
      if (w_hdr_acc) begin
        r_cnt     <= '0;
        r_len_err <= 1'b0;
      end else if (w_cnt_inc && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_CHECK) r_len_err <= (r_cnt != r_hdr[WIDTH-1:ADDR_W]);
    end
  end

  assign len_err = r_len_err;
`else
  assign len_err = 1'b0;
`endif

  assign busy        = (r_state == S_HDR) || (r_state == S_HOLD) || (r_state == S_CHECK);
  assign dout        = r_dout;
  assign wr_en       = r_wr_en;
  assign wr_sel      = r_sel;
  assign parity_done = r_parity_done;
  assign err         = r_err;
  assign drop        = r_drop;

endmodule

// File: tb/tb_router_pkt_reg_gen.sv
// Scoreboard bench for router_pkt_reg_gen (WIDTH=8, ADDR_W=2, NCH=3).
// Stimulus pushes the expected FIFO byte stream and per-packet results into queues;
// a negedge monitor pops and compares whenever the DUT writes, completes or drops.
module tb_router_pkt_reg_gen;

  typedef struct packed {
    logic [7:0] b;
    logic [2:0] sel;
  } wr_t;

  typedef struct packed {
    logic is_drop;
    logic err;
    logic len;
  } res_t;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [2:0] fifo_full;
  logic       busy;
  logic [7:0] dout;
  logic       wr_en;
  logic [2:0] wr_sel;
  logic       parity_done;
  logic       err;
  logic       drop;
  logic       len_err;

  logic       stall_en = 1'b0;
  logic [2:0] rnd_full = 3'b000;
  logic [2:0] dir_full = 3'b000;

  wr_t        exp_q[$];
  res_t       res_q[$];
  logic [7:0] payload[$];

  int n_cmp = 0;
  int n_bad = 0;

  assign fifo_full = stall_en ? rnd_full : dir_full;

  always #5 clock = ~clock;

  router_pkt_reg_gen #(
    .WIDTH (8),
    .ADDR_W(2),
    .NCH   (3)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .pkt_valid  (pkt_valid),
    .data_in    (data_in),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .dout       (dout),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .parity_done(parity_done),
    .err        (err),
    .drop       (drop),
    .len_err    (len_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Random FIFO back-pressure on all channels, including unselected ones.
  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) rnd_full[i] = ($urandom_range(0, 9) < 3);
  end

  // Monitor: compare every DUT event against the head of the matching queue.
  always @(negedge clock) begin : mon
    wr_t  e;
    res_t r;
    if (resetn) begin
      if (wr_en) begin
        if (exp_q.size() == 0) fail_now("unexpected write");
        else begin
          e = exp_q.pop_front();
          chk("dout", {24'd0, dout}, {24'd0, e.b});
          chk("wr_sel", {29'd0, wr_sel}, {29'd0, e.sel});
        end
      end
      if (parity_done) begin
        if (res_q.size() == 0) fail_now("unexpected parity_done");
        else begin
          r = res_q.pop_front();
          chk("done is not drop", {31'd0, r.is_drop}, 32'd0);
          chk("err", {31'd0, err}, {31'd0, r.err});
          chk("len_err", {31'd0, len_err}, {31'd0, r.len});
        end
      end
      if (drop) begin
        if (res_q.size() == 0) fail_now("unexpected drop");
        else begin
          r = res_q.pop_front();
          chk("drop kind", {31'd0, r.is_drop}, 32'd1);
        end
      end
    end
  end

  // Drive one byte and return at the posedge that consumes it (busy low beforehand).
  task automatic send_byte(input logic [7:0] b, input logic v, output int stalls);
    bit done;
    done   = 0;
    stalls = 0;
    @(negedge clock);
    pkt_valid = v;
    data_in   = b;
    for (int k = 0; k < 200 && !done; k++) begin
      if (!busy) begin
        @(posedge clock);
        done = 1;
      end else begin
        stalls++;
        @(negedge clock);
      end
    end
    if (!done) fail_now("busy timeout");
  endtask

  function automatic logic [7:0] xor_all(input logic [7:0] hdr);
    logic [7:0] x;
    x = hdr;
    foreach (payload[i]) x ^= payload[i];
    return x;
  endfunction

  // Reference model: what the FIFO should see and how the packet should end.
  task automatic expect_pkt(input logic [7:0] hdr, input logic [7:0] par);
    logic [2:0] sel;
    logic       lenb;
    int         n;
    n    = payload.size();
    lenb = 1'b0;
    if (hdr[1:0] < 2'd3) begin
      sel = 3'b001 << hdr[1:0];
      exp_q.push_back('{b: hdr, sel: sel});
      foreach (payload[i]) exp_q.push_back('{b: payload[i], sel: sel});
      exp_q.push_back('{b: par, sel: sel});
`ifdef ROUTER_LEN_CHECK_EN
      lenb = ((n > 63 ? 63 : n) != int'(hdr[7:2]));
`endif
      res_q.push_back('{is_drop: 1'b0, err: (xor_all(hdr) != par), len: lenb});
    end else begin
      res_q.push_back('{is_drop: 1'b1, err: 1'b0, len: 1'b0});
    end
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] par, input bit chk_clear,
                          output int tail_stalls);
    int st;
    expect_pkt(hdr, par);
    send_byte(hdr, 1'b1, st);
    if (chk_clear) begin
      #1;
      chk("err cleared on accept", {31'd0, err}, 32'd0);
    end
    tail_stalls = 0;
    foreach (payload[i]) begin
      send_byte(payload[i], 1'b1, st);
      tail_stalls += st;
    end
    send_byte(par, 1'b0, st);
    tail_stalls += st;
  endtask

  initial begin
    int         st;
    int         n;
    logic [7:0] hdr;
    logic [7:0] par;
    logic [5:0] l;
    logic [1:0] addr;

    #23;
    chk("reset outputs", {15'd0, busy, wr_en, dout, wr_sel, parity_done, err, drop, len_err},
        32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // Channel 1, three payload bytes, correct parity.
    payload = '{8'h11, 8'h22, 8'h33};
    send_pkt(8'h0D, 8'h0D, 1'b0, st);

    // Same packet with a bad parity byte; err must persist in IDLE.
    send_pkt(8'h0D, 8'hFF, 1'b0, st);
    repeat (5) @(negedge clock);
    chk("err held in idle", {31'd0, err}, 32'd1);

    // Length field 2 with three payload bytes, correct parity; also clears err on accept.
    payload = '{8'h01, 8'h02, 8'h03};
    send_pkt(8'h0A, xor_all(8'h0A), 1'b1, st);

    // Channel 0 stalled for four cycles on the second payload byte.
    payload = '{8'hA1, 8'hB2};
    par     = xor_all(8'h08);
    expect_pkt(8'h08, par);
    send_byte(8'h08, 1'b1, st);
    send_byte(8'hA1, 1'b1, st);
    #1 dir_full = 3'b001;
    send_byte(8'hB2, 1'b1, st);
    fork
      send_byte(par, 1'b0, st);
      begin
        repeat (4) @(negedge clock);
        dir_full = 3'b000;
      end
    join
    chk("stall cycles on held byte", st, 32'd4);

    // Illegal address: no writes, no back-pressure, one drop pulse.
    payload = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
    send_pkt(8'h03, 8'h77, 1'b0, st);
    chk("drop packet never stalls", st, 32'd0);

    // Asynchronous reset in the middle of DATA, right after the header write.
    repeat (4) @(negedge clock);
    exp_q.push_back('{b: 8'h05, sel: 3'b010});
    send_byte(8'h05, 1'b1, st);
    @(negedge clock);
    data_in = 8'h77;
    @(posedge clock);
    @(negedge clock);
    #2 resetn = 1'b0;
    pkt_valid = 1'b0;
    #1;
    chk("async reset outputs", {15'd0, busy, wr_en, dout, wr_sel, parity_done, err, drop, len_err},
        32'd0);
    @(negedge clock);
    #2 resetn = 1'b1;
    chk("idle after reset", {31'd0, busy}, 32'd0);
    payload = '{8'h44};
    send_pkt(8'h06, xor_all(8'h06), 1'b0, st);

    // Randomized packets under random back-pressure.
    stall_en = 1'b1;
    for (int p = 0; p < 80; p++) begin
      n = $urandom_range(0, 6);
      payload.delete();
      repeat (n) payload.push_back(8'($urandom_range(0, 255)));
      addr = 2'($urandom_range(0, 3));
      l    = ($urandom_range(0, 1) == 1) ? 6'(n) : 6'($urandom_range(0, 7));
      hdr  = {l, addr};
      par  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : xor_all(hdr);
      send_pkt(hdr, par, 1'b0, st);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clock);
        pkt_valid = 1'b0;
        data_in   = 8'($urandom_range(0, 255));
      end
    end

    stall_en = 1'b0;
    for (int k = 0; k < 200 && (exp_q.size() + res_q.size()) != 0; k++) @(negedge clock);
    chk("scoreboard drained", exp_q.size() + res_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
